// File: rtl/tick_counter_pkg.sv
// Shared mode codes and FSM state encoding for the tick counter.
package tick_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_e;

endpackage

// File: rtl/tick_counter_rise_detect.sv
// Single-cycle rising-edge detector for a strobe already in the clk domain.
module tick_counter_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/tick_counter.sv
// Up/down event counter with programmable limit, mode-dependent terminal handling
// and a per-reference-period snapshot of the running count.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int                  CNT_WIDTH = 8,
    parameter logic [CNT_WIDTH-1:0] RST_LIMIT = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_clk,
    input  logic                 ref_clk,
    input  logic                 enable,
    input  logic                 up_down,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic [CNT_WIDTH-1:0] limit_in,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] snapshot,
    output logic                 snap_valid,
    output logic                 wrap,
    output logic                 overflow,
    output logic                 done
);

    logic inc_rise;
    logic ref_rise;

    tick_counter_rise_detect u_inc_rise (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (inc_clk),
        .rise_o (inc_rise)
    );

    tick_counter_rise_detect u_ref_rise (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (ref_clk),
        .rise_o (ref_rise)
    );

    state_e               state_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] limit_q;
    logic [CNT_WIDTH-1:0] snapshot_q;
    logic                 snap_valid_q;
    logic                 wrap_q;
    logic                 overflow_q;
    logic                 done_q;

    logic [CNT_WIDTH-1:0] up_d;
    logic [CNT_WIDTH-1:0] dn_d;
    logic                 at_top;
    logic                 at_bot;

    // Up terminal uses >= so a preset above the limit still counts as terminal.
    always_comb begin
        up_d   = count_q + 1'b1;
        dn_d   = count_q - 1'b1;
        at_top = (count_q >= limit_q);
        at_bot = (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            limit_q      <= RST_LIMIT;
            snapshot_q   <= '0;
            snap_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            snap_valid_q <= ref_rise;
            wrap_q       <= 1'b0;
            if (ref_rise) begin
                snapshot_q <= count_q;
            end

            if (load) begin
                count_q    <= load_val;
                limit_q    <= limit_in;
                overflow_q <= 1'b0;
                done_q     <= 1'b0;
                state_q    <= enable ? ST_RUN : ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (!enable) begin
                            state_q <= ST_IDLE;
                        end else if (inc_rise) begin
                            case (mode)
                                MODE_WRAP: begin
                                    if (up_down) begin
                                        count_q <= at_top ? '0 : up_d;
                                        wrap_q  <= at_top;
                                    end else begin
                                        count_q <= at_bot ? limit_q : dn_d;
                                        wrap_q  <= at_bot;
                                    end
                                end
                                MODE_SAT: begin
                                    if (up_down ? at_top : at_bot) begin
                                        overflow_q <= 1'b1;
                                    end else begin
                                        count_q <= up_down ? up_d : dn_d;
                                    end
                                end
                                MODE_ONESHOT: begin
                                    if (up_down ? at_top : at_bot) begin
                                        state_q <= ST_STOP;
                                        done_q  <= 1'b1;
                                    end else begin
                                        count_q <= up_down ? up_d : dn_d;
                                        if (up_down ? (up_d == limit_q) : (dn_d == '0)) begin
                                            state_q <= ST_STOP;
                                            done_q  <= 1'b1;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_STOP: begin
                        if (!enable) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign count      = count_q;
    assign snapshot   = snapshot_q;
    assign snap_valid = snap_valid_q;
    assign wrap       = wrap_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed-vector bench for tick_counter with hand-computed expectations.
module tb_tick_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inc_clk = 1'b0;
    logic       ref_clk = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] limit_in = 8'd0;
    logic [7:0] count;
    logic [7:0] snapshot;
    logic       snap_valid;
    logic       wrap;
    logic       overflow;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    tick_counter dut (
        .clk        (clk),
        .reset      (reset),
        .inc_clk    (inc_clk),
        .ref_clk    (ref_clk),
        .enable     (enable),
        .up_down    (up_down),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .limit_in   (limit_in),
        .count      (count),
        .snapshot   (snapshot),
        .snap_valid (snap_valid),
        .wrap       (wrap),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] m, input logic ud,
                           input logic [7:0] lv, input logic [7:0] lim);
        mode = m; up_down = ud; load_val = lv; limit_in = lim;
        enable = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if ({count, snapshot, snap_valid, wrap, overflow, done} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_init: got cnt=%0d snap=%0d flags=%b want 0", count, snapshot,
                     {snap_valid, wrap, overflow, done});
        end
        do_load(2'b01, 1'b1, 8'd4, 8'hFF);
        inc_clk = 1'b1; tick(); inc_clk = 1'b0;
        ref_clk = 1'b1; tick(); ref_clk = 1'b0;
        vectors++;
        if (count !== 8'd5 || snapshot !== 8'd5) begin
            miscompares++;
            $display("FAIL pre_reset: got cnt=%0d snap=%0d want 5/5", count, snapshot);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if ({count, snapshot, snap_valid, wrap, overflow, done} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got cnt=%0d snap=%0d flags=%b want 0", count, snapshot,
                     {snap_valid, wrap, overflow, done});
        end
        // limit after reset seen through a WRAP-down underflow
        mode = 2'b00; up_down = 1'b0; enable = 1'b1;
        tick();
        inc_clk = 1'b1; tick(); inc_clk = 1'b0;
        vectors++;
        if (count !== 8'hFF || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_limit: got cnt=%0h wrap=%b want ff/1", count, wrap);
        end
        tick();
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_cnt [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        int wraps = 0;
        do_load(2'b00, 1'b1, 8'd0, 8'd3);
        for (int i = 0; i < 5; i++) begin
            inc_clk = 1'b1; tick(); inc_clk = 1'b0;
            wraps += int'(wrap);
            vectors++;
            if (count !== exp_cnt[i] || wrap !== (i == 3)) begin
                miscompares++;
                $display("FAIL wrap_up[%0d]: got cnt=%0d wrap=%b want %0d/%b", i, count, wrap,
                         exp_cnt[i], (i == 3));
            end
            tick();
            wraps += int'(wrap);
        end
        vectors++;
        if (wraps != 1) begin
            miscompares++;
            $display("FAIL wrap_up_count: got %0d wrap cycles want 1", wraps);
        end
    endtask

    task automatic test_wrap_down();
        do_load(2'b00, 1'b0, 8'd0, 8'd9);
        inc_clk = 1'b1; tick(); inc_clk = 1'b0;
        vectors++;
        if (count !== 8'd9 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_down: got cnt=%0d wrap=%b want 9/1", count, wrap);
        end
        tick();
        vectors++;
        if (wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pulse: got wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_sat();
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd2, 8'd2};
        do_load(2'b01, 1'b1, 8'd0, 8'd2);
        for (int i = 0; i < 4; i++) begin
            inc_clk = 1'b1; tick(); inc_clk = 1'b0; tick();
            vectors++;
            if (count !== exp_cnt[i] || overflow !== (i >= 2)) begin
                miscompares++;
                $display("FAIL sat[%0d]: got cnt=%0d ovf=%b want %0d/%b", i, count, overflow,
                         exp_cnt[i], (i >= 2));
            end
        end
        do_load(2'b01, 1'b1, 8'd0, 8'd2);
        vectors++;
        if (overflow !== 1'b0 || count !== 8'd0) begin
            miscompares++;
            $display("FAIL sat_clear: got ovf=%b cnt=%0d want 0/0", overflow, count);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_cnt [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
        do_load(2'b10, 1'b1, 8'd0, 8'd4);
        for (int i = 0; i < 6; i++) begin
            inc_clk = 1'b1; tick(); inc_clk = 1'b0; tick();
            vectors++;
            if (count !== exp_cnt[i] || done !== (i >= 3)) begin
                miscompares++;
                $display("FAIL oneshot[%0d]: got cnt=%0d done=%b want %0d/%b", i, count, done,
                         exp_cnt[i], (i >= 3));
            end
        end
        enable = 1'b0; tick();
        vectors++;
        if (done !== 1'b0 || count !== 8'd4) begin
            miscompares++;
            $display("FAIL oneshot_idle: got done=%b cnt=%0d want 0/4", done, count);
        end
        inc_clk = 1'b1; tick(); inc_clk = 1'b0; tick();
        vectors++;
        if (count !== 8'd4) begin
            miscompares++;
            $display("FAIL idle_ignore: got cnt=%0d want 4", count);
        end
    endtask

    task automatic test_level_and_snapshot();
        do_load(2'b00, 1'b1, 8'd0, 8'hFF);
        inc_clk = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        inc_clk = 1'b0; tick();
        vectors++;
        if (count !== 8'd1) begin
            miscompares++;
            $display("FAIL level_held: got cnt=%0d want 1", count);
        end
        do_load(2'b00, 1'b1, 8'd7, 8'hFF);
        inc_clk = 1'b1; ref_clk = 1'b1; tick();
        inc_clk = 1'b0; ref_clk = 1'b0;
        vectors++;
        if (snapshot !== 8'd7 || count !== 8'd8 || snap_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL snap_same: got snap=%0d cnt=%0d sv=%b want 7/8/1", snapshot, count,
                     snap_valid);
        end
        tick();
        vectors++;
        if (snap_valid !== 1'b0 || snapshot !== 8'd7) begin
            miscompares++;
            $display("FAIL snap_pulse: got sv=%b snap=%0d want 0/7", snap_valid, snapshot);
        end
    endtask

    task automatic test_boundaries();
        do_load(2'b00, 1'b1, 8'd0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            inc_clk = 1'b1; tick(); inc_clk = 1'b0;
            vectors++;
            if (count !== 8'd0 || wrap !== 1'b1) begin
                miscompares++;
                $display("FAIL limit0[%0d]: got cnt=%0d wrap=%b want 0/1", i, count, wrap);
            end
            tick();
        end
        do_load(2'b01, 1'b1, 8'd10, 8'd5);
        inc_clk = 1'b1; tick(); inc_clk = 1'b0; tick();
        vectors++;
        if (count !== 8'd10 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_over: got cnt=%0d ovf=%b want 10/1", count, overflow);
        end
        do_load(2'b00, 1'b1, 8'd10, 8'd5);
        inc_clk = 1'b1; tick(); inc_clk = 1'b0;
        vectors++;
        if (count !== 8'd0 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_over: got cnt=%0d wrap=%b want 0/1", count, wrap);
        end
        tick();
        // load wins over a coincident increment edge
        mode = 2'b00; up_down = 1'b1; load_val = 8'd20; limit_in = 8'hFF;
        load = 1'b1; inc_clk = 1'b1; tick();
        load = 1'b0; tick(); inc_clk = 1'b0; tick();
        vectors++;
        if (count !== 8'd20) begin
            miscompares++;
            $display("FAIL load_prio: got cnt=%0d want 20", count);
        end
        mode = 2'b11;
        inc_clk = 1'b1; tick(); inc_clk = 1'b0; tick();
        vectors++;
        if (count !== 8'd20 || wrap !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: got cnt=%0d wrap=%b ovf=%b want 20/0/0", count, wrap, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat();
        test_oneshot();
        test_level_and_snapshot();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
